boot_host: RTL and testbench
============================

# boot_host

Host-side responder for the UART program-load protocol, synthesizable so the CPU's loader can run without a PC (loopback bench, second-board boot). It waits for the CPU's 0x99 request and answers with a 4-byte little-endian program size. It then streams the program words, waits for the CPU's 0xaa acknowledge, and streams the data words, all read from a word-addressed ROM. It sits between an external UART receiver/sender pair and a synchronous-read ROM.

## Interface
- PROG_WORDS, 16: program length in 32-bit words; 0 allowed
- DATA_WORDS, 16: data length in 32-bit words; 0 allowed
- ADDR_W, 10: ROM address width; PROG_WORDS+DATA_WORDS ≤ 2**ADDR_W
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_ready  in  1  one-cycle pulse: rdata valid
- rdata  in  8  received byte
- tx_busy  in  1  sender shifting a byte; rises the cycle after tx_start
- tx_start  out  1  one-cycle pulse: send sdata
- sdata  out  8  byte to send; stable from tx_start until next tx_start
- rom_addr  out  ADDR_W  word address
- rom_rdata  in  32  ROM word, valid one cycle after rom_addr
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE
- state_dbg  out  6  one-hot state, for LEDs

## Operation
- Reset values: tx_start=0, sdata=0, rom_addr=0, busy=0, done=0, state IDLE, all counters 0.
- States: IDLE, SIZE, PROG, WAIT_ACK, DATA, DONE.
- IDLE: rx_ready with rdata=0x99 → SIZE; any other byte is ignored.
- SIZE: send PROG_WORDS*4 as 32 bits, LSB byte first (4 bytes). Then → PROG if PROG_WORDS>0, else → WAIT_ACK.
- PROG: for word i=0..PROG_WORDS-1, read rom[i] and send its 4 bytes LSB first. After the last byte's tx_start → WAIT_ACK.
- WAIT_ACK: rx_ready with 0xaa → DATA if DATA_WORDS>0, else → DONE; other bytes ignored. 0xaa is accepted even while tx_busy is high for the final program byte.
- DATA: rom[PROG_WORDS+j], j=0..DATA_WORDS-1, same byte order. After the last byte's tx_start → DONE.
- DONE: rx_ready with 0x99 → SIZE (rebooted CPU restarts the load); other bytes ignored.
- rx_ready in SIZE/PROG/DATA is ignored.
- Size arithmetic is 32-bit; PROG_WORDS*4 is computed at elaboration.
- Word counter is ADDR_W+1 bits; there is no wrap, the terminal count ends the phase.

## Timing
- Byte issue rule: tx_start only when tx_busy=0 and tx_start was 0 in the previous cycle. This gives a minimum gap of 2 cycles between starts, covering the sender's one-cycle busy latency.
- Entering SIZE: first tx_start 1 cycle after the 0x99 rx_ready.
- Word fetch: rom_addr is driven in the cycle the word counter advances. rom_rdata is latched into a 32-bit shift register the next cycle, and byte 0 may start the cycle after that. ROM latency is therefore hidden only at word boundaries, and 2 cycles are added per word at most.
- sdata and tx_start change on the same edge.
- Reset mid-operation: immediate return to IDLE with tx_start low. A byte already in the external sender is not aborted, and the CPU side must also be reset.
- busy and done are registered and track the state with no extra lag.

## Structure
- Package boot_host_pkg: state enum (one-hot, 6 bits), BOOT_REQ=8'h99, BOOT_ACK=8'haa.
- Sub-module word_serializer: takes a 32-bit word plus a load strobe, emits 4 bytes LSB-first under the tx_start/tx_busy rule, and raises word_done. It is shared by SIZE (loaded from the constant), PROG and DATA.
- Top: FSM, word counter, ROM address mux, rx byte matching.

## Test plan
- PROG_WORDS=2, DATA_WORDS=1, rom={0x11223344,0xAABBCCDD,0xDEADBEEF}. Send 0x99 → bytes 08 00 00 00 44 33 22 11 DD CC BB AA. Send 0xaa → EF BE AD DE, then done=1.
- Bytes 0x00, 0x55 in IDLE → no tx_start and state stays IDLE. Then 0x99 → size bytes sent.
- PROG_WORDS=0, DATA_WORDS=0: 0x99 → 00 00 00 00 then WAIT_ACK. 0xaa → DONE with no further tx_start.
- Hold tx_busy high for 50 cycles after each start → exactly one tx_start per byte, never while busy, sdata stable throughout.
- Reset asserted after the 3rd program byte → outputs at reset values next cycle. A new 0x99 restarts from the size bytes.
- In DONE, send 0x99 → full sequence repeats identically. A 0xaa sent during PROG is ignored and the host still waits in WAIT_ACK.

Source files
------------

// File: rtl/boot_host_pkg.sv
// Shared definitions for the UART program-load host responder.
package boot_host_pkg;

  // One-hot states; the encoding is exported directly on state_dbg.
  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_SIZE     = 6'b000010,
    S_PROG     = 6'b000100,
    S_WAIT_ACK = 6'b001000,
    S_DATA     = 6'b010000,
    S_DONE     = 6'b100000
  } state_t;

  // Protocol bytes sent by the CPU-side loader.
  localparam logic [7:0] BOOT_REQ = 8'h99;
  localparam logic [7:0] BOOT_ACK = 8'haa;

endpackage

// File: rtl/boot_host_word_serializer.sv
// Sends a 32-bit word as 4 bytes, LSB first, to a UART sender.
//
// Handshake: a byte is issued (tx_start pulse, sdata updated on the same edge)
// only when tx_busy is low and tx_start was low in the previous cycle. This
// leaves two cycles between starts, which covers the sender's one-cycle delay
// before tx_busy rises. A load may issue byte 0 on the very edge it arrives.
// word_done is high in the cycle whose edge issues byte 3, so the caller can
// change phase on the same edge that the last tx_start appears.
module word_serializer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  sdata,
  output logic        word_done
);

  logic [31:0] shreg;
  logic [1:0]  cnt;
  logic        active;

  logic [31:0] cur_word;
  logic [1:0]  cur_cnt;
  logic        issue;

  // Select the freshly loaded word or the remaining bytes and decide on issue.
  always_comb begin
    cur_word  = load ? word : shreg;
    cur_cnt   = load ? 2'd0 : cnt;
    issue     = (load || active) && !tx_busy && !tx_start;
    word_done = issue && (cur_cnt == 2'd3);
  end

  // Byte shift register, byte counter and the registered tx_start/sdata.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg    <= '0;
      cnt      <= '0;
      active   <= 1'b0;
      tx_start <= 1'b0;
      sdata    <= '0;
    end else begin
      tx_start <= issue;
      if (issue) begin
        sdata  <= cur_word[7:0];
        shreg  <= {8'h00, cur_word[31:8]};
        cnt    <= cur_cnt + 2'd1;
        active <= (cur_cnt != 2'd3);
      end else if (load) begin
        shreg  <= word;
        cnt    <= 2'd0;
        active <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/boot_host.sv
// Host-side responder for the UART program-load protocol: answers the CPU's
// request with the program size, streams program words, waits for the
// acknowledge, then streams data words, all read from a synchronous ROM.
module boot_host
  import boot_host_pkg::*;
#(
  parameter int PROG_WORDS = 16,
  parameter int DATA_WORDS = 16,
  parameter int ADDR_W     = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_ready,
  input  logic [7:0]        rdata,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        sdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic              busy,
  output logic              done,
  output logic [5:0]        state_dbg
);

  localparam logic [31:0]   SIZE_WORD = 32'(PROG_WORDS * 4);
  localparam logic [ADDR_W:0] PROG_CNT = (ADDR_W + 1)'(PROG_WORDS);
  localparam logic [ADDR_W:0] DATA_CNT = (ADDR_W + 1)'(DATA_WORDS);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  state_t            state, state_nx;
  logic [ADDR_W:0]   word_cnt;
  logic              fetch_q, load_q;
  logic              start_fetch;
  logic [ADDR_W:0]   fetch_idx, fetch_base;
  logic [ADDR_W-1:0] fetch_addr;
  logic              rx_req, rx_ack, go_size;
  logic              ser_load, word_done;
  logic [31:0]       ser_word;

  assign rx_req     = rx_ready && (rdata == BOOT_REQ);
  assign rx_ack     = rx_ready && (rdata == BOOT_ACK);
  assign fetch_addr = ADDR_W'(fetch_base + fetch_idx);
  // The size word loads on the request edge; ROM words load once rom_rdata
  // is valid, two cycles after the fetch was decided.
  assign ser_load   = go_size || load_q;
  assign ser_word   = go_size ? SIZE_WORD : rom_rdata;
  assign state_dbg  = state;

  word_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (ser_load),
    .word      (ser_word),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .sdata     (sdata),
    .word_done (word_done)
  );

  // Next-state logic plus the fetch request and its ROM address components.
  always_comb begin
    state_nx    = state;
    go_size     = 1'b0;
    start_fetch = 1'b0;
    fetch_idx   = '0;
    fetch_base  = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (rx_req) begin
          state_nx = S_SIZE;
          go_size  = 1'b1;
        end
      end
      S_SIZE: begin
        if (word_done) begin
          if (PROG_WORDS > 0) begin
            state_nx    = S_PROG;
            start_fetch = 1'b1;
          end else begin
            state_nx = S_WAIT_ACK;
          end
        end
      end
      S_PROG: begin
        if (word_done) begin
          if (word_cnt == PROG_CNT) begin
            state_nx = S_WAIT_ACK;
          end else begin
            start_fetch = 1'b1;
            fetch_idx   = word_cnt;
          end
        end
      end
      S_WAIT_ACK: begin
        if (rx_ack) begin
          if (DATA_WORDS > 0) begin
            state_nx    = S_DATA;
            start_fetch = 1'b1;
            fetch_base  = PROG_CNT;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_DATA: begin
        if (word_done) begin
          if (word_cnt == DATA_CNT) begin
            state_nx = S_DONE;
          end else begin
            start_fetch = 1'b1;
            fetch_idx   = word_cnt;
            fetch_base  = PROG_CNT;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      done  <= (state_nx == S_DONE);
    end
  end

  // Word counter, ROM address and the two-stage fetch-to-load pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt <= '0;
      rom_addr <= '0;
      fetch_q  <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      fetch_q <= start_fetch;
      load_q  <= fetch_q;
      if (start_fetch) begin
        rom_addr <= fetch_addr;
        word_cnt <= fetch_idx + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_boot_host.sv
// Bench for boot_host: a 2/1-word configuration with a ROM and sender model,
// and a 0/0-word configuration checked alongside.
module tb_boot_host;

  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_SIZE = 6'b000010;
  localparam logic [5:0] ST_PROG = 6'b000100;
  localparam logic [5:0] ST_WACK = 6'b001000;
  localparam logic [5:0] ST_DONE = 6'b100000;

  logic        clock, reset;
  logic        rx_ready, tx_busy, tx_start, busy, done;
  logic [7:0]  rdata, sdata;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata;
  logic [5:0]  state_dbg;

  logic        rx_ready_z, tx_busy_z, tx_start_z, busy_z, done_z;
  logic [7:0]  rdata_z, sdata_z;
  logic [9:0]  rom_addr_z;
  logic [31:0] rom_rdata_z;
  logic [5:0]  state_dbg_z;

  logic [31:0] rom [1024];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_z[$];
  logic [7:0]  seq_boot [12];
  logic [7:0]  seq_data [4];
  logic [7:0]  exp_b, last_sdata;
  logic        busy_at_edge, start_at_edge;
  int          busy_hold, busy_left;
  bit          arm;
  int          checks, failures;

  boot_host #(.PROG_WORDS(2), .DATA_WORDS(1), .ADDR_W(10)) dut (
    .clock(clock), .reset(reset), .rx_ready(rx_ready), .rdata(rdata),
    .tx_busy(tx_busy), .tx_start(tx_start), .sdata(sdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  boot_host #(.PROG_WORDS(0), .DATA_WORDS(0), .ADDR_W(10)) dut_z (
    .clock(clock), .reset(reset), .rx_ready(rx_ready_z), .rdata(rdata_z),
    .tx_busy(tx_busy_z), .tx_start(tx_start_z), .sdata(sdata_z),
    .rom_addr(rom_addr_z), .rom_rdata(rom_rdata_z), .busy(busy_z), .done(done_z),
    .state_dbg(state_dbg_z)
  );

  // ---------------- clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- synchronous-read ROM model
  always @(posedge clock) rom_rdata <= rom[rom_addr];

  // ---------------- UART sender model: busy rises the cycle after tx_start
  always @(negedge clock) begin
    if (busy_left > 0) busy_left--;
    if (arm) begin
      busy_left = busy_hold;
      arm = 1'b0;
    end
    if (tx_start) arm = 1'b1;
    tx_busy = (busy_left > 0);
  end

  // What the DUT saw on the edge that could have launched a byte.
  always @(posedge clock) begin
    busy_at_edge  <= tx_busy;
    start_at_edge <= tx_start;
  end

  // ---------------- scoreboard monitor, main instance
  always @(negedge clock) begin
    if (reset) begin
      last_sdata = sdata;
    end else begin
      if (tx_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL tx_extra got=%h expected=none", sdata);
        end else begin
          exp_b = exp_q.pop_front();
          if (sdata !== exp_b) begin
            failures++;
            $display("FAIL tx_byte got=%h expected=%h", sdata, exp_b);
          end
        end
        checks++;
        if (busy_at_edge || start_at_edge) begin
          failures++;
          $display("FAIL issue_rule busy=%b prev_start=%b expected=0,0", busy_at_edge, start_at_edge);
        end
      end else begin
        checks++;
        if (sdata !== last_sdata) begin
          failures++;
          $display("FAIL sdata_hold got=%h expected=%h", sdata, last_sdata);
        end
      end
      last_sdata = sdata;
    end
  end

  // ---------------- scoreboard monitor, zero-length instance
  always @(negedge clock) begin
    if (!reset && tx_start_z) begin
      checks++;
      if (exp_z.size() == 0) begin
        failures++;
        $display("FAIL z_tx_extra got=%h expected=none", sdata_z);
      end else begin
        exp_b = exp_z.pop_front();
        if (sdata_z !== exp_b) begin
          failures++;
          $display("FAIL z_tx_byte got=%h expected=%h", sdata_z, exp_b);
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input bit to_z, input logic [7:0] b);
    @(negedge clock);
    if (to_z) begin
      rdata_z = b;
      rx_ready_z = 1'b1;
    end else begin
      rdata = b;
      rx_ready = 1'b1;
    end
    @(negedge clock);
    rx_ready   = 1'b0;
    rx_ready_z = 1'b0;
  endtask

  task automatic push_boot(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(seq_boot[i]);
  endtask

  task automatic push_data();
    for (int i = 0; i < 4; i++) exp_q.push_back(seq_data[i]);
  endtask

  task automatic drain(input string name, input bit to_z, input int budget);
    int n;
    n = 0;
    while ((to_z ? exp_z.size() : exp_q.size()) != 0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    check(name, 32'(to_z ? exp_z.size() : exp_q.size()), 32'd0);
  endtask

  task automatic wait_state(input string name, input logic [5:0] st, input int budget);
    int n;
    n = 0;
    while (state_dbg !== st && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    check(name, 32'(state_dbg), 32'(st));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_sdata"},    32'(sdata),    32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_state"},    32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog
  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence
  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    rx_ready = 1'b0; rdata = 8'h00; tx_busy = 1'b0;
    rx_ready_z = 1'b0; rdata_z = 8'h00; tx_busy_z = 1'b0; rom_rdata_z = 32'hffff_ffff;
    busy_hold = 3; busy_left = 0; arm = 1'b0;
    busy_at_edge = 1'b0; start_at_edge = 1'b0; last_sdata = 8'h00;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    rom[0] = 32'h1122_3344;
    rom[1] = 32'hAABB_CCDD;
    rom[2] = 32'hDEAD_BEEF;
    seq_boot = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    seq_data = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    wait_cycles(3);
    check_reset_values("rst");
    reset = 1'b0;
    wait_cycles(2);

    // Zero-length configuration: size bytes only, then ack straight to DONE.
    for (int i = 0; i < 4; i++) exp_z.push_back(8'h00);
    send_byte(1'b1, 8'h99);
    drain("z_size", 1'b1, 50);
    wait_cycles(2);
    check("z_wait_ack_state", 32'(state_dbg_z), 32'(ST_WACK));
    check("z_wait_ack_busy", 32'(busy_z), 32'd1);
    send_byte(1'b1, 8'haa);
    wait_cycles(10);
    check("z_done_state", 32'(state_dbg_z), 32'(ST_DONE));
    check("z_done", 32'(done_z), 32'd1);
    check("z_busy", 32'(busy_z), 32'd0);

    // Non-request bytes in IDLE are ignored.
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h55);
    wait_cycles(8);
    check("idle_ignore_state", 32'(state_dbg), 32'(ST_IDLE));
    check("idle_ignore_busy", 32'(busy), 32'd0);

    // Full boot; first byte appears one cycle after the request.
    push_boot(12);
    send_byte(1'b0, 8'h99);
    check("size_latency_start", 32'(tx_start), 32'd1);
    check("size_latency_sdata", 32'(sdata), 32'h08);
    check("size_state", 32'(state_dbg), 32'(ST_SIZE));
    wait_state("reach_prog", ST_PROG, 100);
    send_byte(1'b0, 8'haa);
    drain("boot_bytes", 1'b0, 300);
    wait_cycles(2);
    check("wait_ack_state", 32'(state_dbg), 32'(ST_WACK));
    check("wait_ack_busy", 32'(busy), 32'd1);
    check("wait_ack_done", 32'(done), 32'd0);
    push_data();
    send_byte(1'b0, 8'haa);
    drain("data_bytes", 1'b0, 200);
    wait_cycles(2);
    check("done_state", 32'(state_dbg), 32'(ST_DONE));
    check("done_flag", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);

    // Restart from DONE with a slow sender (busy for 50 cycles per byte).
    busy_hold = 50;
    wait_cycles(60);
    push_boot(12);
    send_byte(1'b0, 8'h99);
    drain("slow_boot_bytes", 1'b0, 1500);
    wait_cycles(2);
    check("slow_wait_ack_state", 32'(state_dbg), 32'(ST_WACK));
    push_data();
    send_byte(1'b0, 8'haa);
    drain("slow_data_bytes", 1'b0, 600);
    wait_cycles(2);
    check("slow_done", 32'(done), 32'd1);
    busy_hold = 3;
    wait_cycles(60);

    // Reset right after the third program byte, then a clean reboot.
    push_boot(7);
    send_byte(1'b0, 8'h99);
    drain("pre_reset_bytes", 1'b0, 200);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check_reset_values("midrst");
    reset = 1'b0;
    wait_cycles(10);
    push_boot(12);
    send_byte(1'b0, 8'h99);
    drain("reboot_bytes", 1'b0, 300);
    push_data();
    send_byte(1'b0, 8'haa);
    drain("reboot_data", 1'b0, 200);
    wait_cycles(5);
    check("reboot_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
